// File: rtl/vsync_conditioner.sv
// vsync_conditioner: synchronizes, deglitches and measures the raw Atari VSYNC.
// Produces a clean active-low vsync on clk, the frame length and VSYNC width
// in whole lines, a one-clock frame strobe and a lock flag for status logic.
//
// Handshake: none. frame_strobe is a single-cycle qualifier; frame_lines and
// locked are valid on the cycle frame_strobe is high and hold until the next
// strobe. vs_lines updates on the cycle the clean vsync rises.
module vsync_conditioner #(
    parameter int LINE_CLKS    = 766,
    parameter int GLITCH_CLKS  = 8,
    parameter int MIN_VS_LINES = 2,
    parameter int MAX_VS_LINES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       vsync_raw,
    output logic       vsync,
    output logic [9:0] frame_lines,
    output logic [2:0] vs_lines,
    output logic       frame_strobe,
    output logic       locked
);

    localparam int CW = (LINE_CLKS > 1) ? $clog2(LINE_CLKS) : 1;
    localparam int GW = $clog2(GLITCH_CLKS + 1);
    localparam logic [CW-1:0] CCNT_MAX  = CW'(LINE_CLKS - 1);
    localparam logic [CW-1:0] CCNT_HALF = CW'(LINE_CLKS / 2);
    localparam logic [GW-1:0] GCNT_MAX  = GW'(GLITCH_CLKS - 1);
    localparam logic [9:0]    LCNT_SAT  = 10'd1023;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_VS_LOW = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    logic          s1_q, s2_q;
    logic          vsync_q, vsync_d;
    logic [GW-1:0] gcnt_q, gcnt_d;
    logic [CW-1:0] ccnt_q, ccnt_d;
    logic [9:0]    lcnt_q, lcnt_d;
    state_t        state_q;
    logic [9:0]    frame_lines_q;
    logic [2:0]    vs_lines_q;
    logic          frame_strobe_q;
    logic          locked_q;
    logic [1:0]    good_q;
    logic          have_prev_q;

    logic          flip, fall, rise, timeout, round_up;
    logic [10:0]   meas_sum;
    logic [9:0]    meas_frame;
    logic [2:0]    meas_vs;
    logic          vs_ok, len_ok, frame_valid;

    // The clean level flips only after GLITCH_CLKS consecutive disagreeing samples.
    assign flip = (s2_q != vsync_q) && (gcnt_q == GCNT_MAX);
    assign fall = flip && vsync_q;
    assign rise = flip && !vsync_q;

    // Measurements round to the nearest line using the clock count at the edge.
    assign timeout    = (lcnt_q == LCNT_SAT);
    assign round_up   = (ccnt_q >= CCNT_HALF);
    assign meas_sum   = {1'b0, lcnt_q} + {10'd0, round_up};
    assign meas_frame = (meas_sum > 11'd1023) ? 10'd1023 : meas_sum[9:0];
    assign meas_vs    = (meas_sum > 11'd7) ? 3'd7 : meas_sum[2:0];

    // Without a previous measurement (after reset or timeout) only the width is judged.
    assign vs_ok  = (vs_lines_q >= 3'(MIN_VS_LINES)) && (vs_lines_q <= 3'(MAX_VS_LINES));
    assign len_ok = !have_prev_q ||
                    (({1'b0, meas_frame} + 11'd1 >= {1'b0, frame_lines_q}) &&
                     ({1'b0, meas_frame} <= {1'b0, frame_lines_q} + 11'd1));
    assign frame_valid = vs_ok && len_ok;

    // Glitch filter next state: count disagreement, commit the new level on expiry.
    always_comb begin
        vsync_d = vsync_q;
        gcnt_d  = '0;
        if (s2_q != vsync_q) begin
            if (gcnt_q == GCNT_MAX) begin
                vsync_d = s2_q;
            end else begin
                gcnt_d = gcnt_q + 1'b1;
            end
        end
    end

    // Line timing next state: a vsync fall restarts both counters and beats a wrap.
    always_comb begin
        ccnt_d = ccnt_q;
        lcnt_d = lcnt_q;
        if (fall) begin
            ccnt_d = '0;
            lcnt_d = '0;
        end else if (ccnt_q == CCNT_MAX) begin
            ccnt_d = '0;
            if (lcnt_q != LCNT_SAT) begin
                lcnt_d = lcnt_q + 10'd1;
            end
        end else begin
            ccnt_d = ccnt_q + 1'b1;
        end
    end

    // Synchronizer, filter and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q    <= 1'b1;
            s2_q    <= 1'b1;
            vsync_q <= 1'b1;
            gcnt_q  <= '0;
            ccnt_q  <= '0;
            lcnt_q  <= '0;
        end else begin
            s1_q    <= vsync_raw;
            s2_q    <= s1_q;
            vsync_q <= vsync_d;
            gcnt_q  <= gcnt_d;
            ccnt_q  <= ccnt_d;
            lcnt_q  <= lcnt_d;
        end
    end

    // Frame FSM: latches width on rise, length on fall, and tracks lock; timeout wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            frame_lines_q  <= '0;
            vs_lines_q     <= '0;
            frame_strobe_q <= 1'b0;
            locked_q       <= 1'b0;
            good_q         <= '0;
            have_prev_q    <= 1'b0;
        end else begin
            frame_strobe_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (fall) begin
                        state_q <= ST_VS_LOW;
                    end
                end
                ST_VS_LOW: begin
                    if (timeout) begin
                        state_q     <= ST_IDLE;
                        locked_q    <= 1'b0;
                        good_q      <= '0;
                        have_prev_q <= 1'b0;
                    end else if (rise) begin
                        vs_lines_q <= meas_vs;
                        state_q    <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (timeout) begin
                        state_q     <= ST_IDLE;
                        locked_q    <= 1'b0;
                        good_q      <= '0;
                        have_prev_q <= 1'b0;
                    end else if (fall) begin
                        frame_lines_q  <= meas_frame;
                        frame_strobe_q <= 1'b1;
                        have_prev_q    <= 1'b1;
                        state_q        <= ST_VS_LOW;
                        if (frame_valid) begin
                            good_q <= (good_q == 2'd3) ? 2'd3 : good_q + 2'd1;
                            if (good_q == 2'd1) begin
                                locked_q <= 1'b1;
                            end
                        end else begin
                            good_q   <= '0;
                            locked_q <= 1'b0;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign vsync        = vsync_q;
    assign frame_lines  = frame_lines_q;
    assign vs_lines     = vs_lines_q;
    assign frame_strobe = frame_strobe_q;
    assign locked       = locked_q;

endmodule

// File: tb/tb_vsync_conditioner.sv
// Bench for vsync_conditioner with a short line length so whole frames fit
// in a short run. Expected strobe results and VSYNC widths are queued when
// the raw stimulus is driven and consumed when the DUT produces them.
module tb_vsync_conditioner;

    localparam int L = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       vsync_raw = 1'b1;
    logic       vsync;
    logic [9:0] frame_lines;
    logic [2:0] vs_lines;
    logic       frame_strobe;
    logic       locked;

    int checks = 0;
    int errors = 0;
    int strobe_cnt = 0;
    logic prev_vsync = 1'b1;

    logic [10:0] exp_frame_q[$];   // {locked, frame_lines}
    logic [2:0]  exp_vs_q[$];

    vsync_conditioner #(
        .LINE_CLKS   (L),
        .GLITCH_CLKS (8),
        .MIN_VS_LINES(2),
        .MAX_VS_LINES(4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .vsync_raw   (vsync_raw),
        .vsync       (vsync),
        .frame_lines (frame_lines),
        .vs_lines    (vs_lines),
        .frame_strobe(frame_strobe),
        .locked      (locked)
    );

    // Clock.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Scoreboard: pop and compare whenever the DUT strobes or vsync rises.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_vsync = 1'b1;
        end else begin
            if (frame_strobe === 1'b1) begin
                logic [10:0] e;
                strobe_cnt++;
                check("strobe_expected", 32'(exp_frame_q.size() != 0), 32'd1);
                if (exp_frame_q.size() != 0) begin
                    e = exp_frame_q.pop_front();
                    check("frame_lines", 32'(frame_lines), 32'(e[9:0]));
                    check("locked_at_strobe", 32'(locked), 32'(e[10]));
                end
            end
            if (prev_vsync === 1'b0 && vsync === 1'b1) begin
                logic [2:0] v;
                check("rise_expected", 32'(exp_vs_q.size() != 0), 32'd1);
                if (exp_vs_q.size() != 0) begin
                    v = exp_vs_q.pop_front();
                    check("vs_lines", 32'(vs_lines), 32'(v));
                end
            end
            prev_vsync = vsync;
        end
    end

    task automatic hold(input logic lvl, input int clocks);
        vsync_raw = lvl;
        repeat (clocks) @(negedge clk);
    endtask

    // One raw frame starting with its VSYNC fall; the fall reports the previous frame.
    task automatic do_frame(input int low_l, input int high_l,
                            input bit push_f, input logic lk, input logic [9:0] fl,
                            input bit push_v, input logic [2:0] vs);
        if (push_f) exp_frame_q.push_back({lk, fl});
        if (push_v) exp_vs_q.push_back(vs);
        hold(1'b0, low_l * L);
        hold(1'b1, high_l * L);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_vsync"}, 32'(vsync), 32'd1);
        check({tag, "_frame_lines"}, 32'(frame_lines), 32'd0);
        check({tag, "_vs_lines"}, 32'(vs_lines), 32'd0);
        check({tag, "_strobe"}, 32'(frame_strobe), 32'd0);
        check({tag, "_locked"}, 32'(locked), 32'd0);
    endtask

    initial begin
        int low_cnt;
        int first_low;
        int n0;

        // Reset state.
        rst_n = 1'b0;
        vsync_raw = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        hold(1'b1, 20);

        // 7-clock raw pulse is swallowed.
        low_cnt = 0;
        first_low = 0;
        vsync_raw = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (i == 7) vsync_raw = 1'b1;
            if (vsync === 1'b0) begin
                low_cnt++;
                if (first_low == 0) first_low = i;
            end
        end
        check("glitch7_low_clocks", 32'(low_cnt), 32'd0);

        // 8-clock raw pulse passes through, 10 clocks late; width rounds to 1 line.
        exp_vs_q.push_back(3'd1);
        low_cnt = 0;
        first_low = 0;
        vsync_raw = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (i == 8) vsync_raw = 1'b1;
            if (vsync === 1'b0) begin
                low_cnt++;
                if (first_low == 0) first_low = i;
            end
        end
        check("glitch8_low_clocks", 32'(low_cnt), 32'd8);
        check("glitch8_latency", 32'(first_low), 32'd10);

        // Back to a clean start for acquisition.
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_clears_vs_lines", 32'(vs_lines), 32'd0);
        rst_n = 1'b1;
        hold(1'b1, 310 * L);

        // Acquisition: no strobe on first fall, lock on third fall.
        do_frame(3, 310, 1'b0, 1'b0, 10'd0,   1'b1, 3'd3);
        do_frame(3, 310, 1'b1, 1'b0, 10'd313, 1'b1, 3'd3);
        do_frame(3, 310, 1'b1, 1'b1, 10'd313, 1'b1, 3'd3);
        // A 320-line frame breaks lock; relock after two valid frames.
        do_frame(3, 317, 1'b1, 1'b1, 10'd313, 1'b1, 3'd3);
        do_frame(3, 310, 1'b1, 1'b0, 10'd320, 1'b1, 3'd3);
        do_frame(3, 310, 1'b1, 1'b0, 10'd313, 1'b1, 3'd3);
        do_frame(3, 310, 1'b1, 1'b0, 10'd313, 1'b1, 3'd3);
        do_frame(3, 310, 1'b1, 1'b1, 10'd313, 1'b1, 3'd3);
        // Over-wide VSYNC of 6 lines drops lock at the following fall.
        do_frame(6, 307, 1'b1, 1'b1, 10'd313, 1'b1, 3'd6);
        do_frame(3, 310, 1'b1, 1'b0, 10'd313, 1'b1, 3'd3);
        do_frame(3, 310, 1'b1, 1'b0, 10'd313, 1'b1, 3'd3);
        do_frame(3, 310, 1'b1, 1'b1, 10'd313, 1'b1, 3'd3);

        // Timeout: raw held high for 1100 lines after a locked fall.
        exp_frame_q.push_back({1'b1, 10'd313});
        exp_vs_q.push_back(3'd3);
        hold(1'b0, 3 * L);
        hold(1'b1, 997 * L);
        check("locked_before_timeout", 32'(locked), 32'd1);
        hold(1'b1, 30 * L);
        check("locked_after_timeout", 32'(locked), 32'd0);
        hold(1'b1, 70 * L);
        n0 = strobe_cnt;
        do_frame(3, 310, 1'b0, 1'b0, 10'd0, 1'b1, 3'd3);
        check("no_strobe_after_timeout", 32'(strobe_cnt - n0), 32'd0);

        // Reset asserted during VS_LOW acts immediately.
        exp_frame_q.push_back({1'b0, 10'd313});
        hold(1'b0, 2 * L);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        vsync_raw = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        hold(1'b1, 310 * L);

        // Re-acquisition after reset.
        n0 = strobe_cnt;
        do_frame(3, 310, 1'b0, 1'b0, 10'd0,   1'b1, 3'd3);
        check("no_strobe_first_fall_after_reset", 32'(strobe_cnt - n0), 32'd0);
        do_frame(3, 310, 1'b1, 1'b0, 10'd313, 1'b1, 3'd3);
        do_frame(3, 310, 1'b1, 1'b1, 10'd313, 1'b1, 3'd3);

        // Every queued expectation must have been produced.
        check("frame_queue_drained", 32'(exp_frame_q.size()), 32'd0);
        check("vs_queue_drained", 32'(exp_vs_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vsync_conditioner.md
# vsync_conditioner

Input conditioning stage directly upstream of the predictive CSYNC generator. It takes the raw, asynchronous, active-low VSYNC from the Atari side and produces a clean VSYNC on `clk`: synchronized, deglitched and edge-aligned. From that clean signal it measures frame length and VSYNC width in lines of `LINE_CLKS` clocks, and raises a lock flag once the frame structure is stable. The CSYNC generator consumes `vsync`; `locked` and the measurements feed status logic.

## Interface
- `LINE_CLKS`, 766: clocks per video line.
- `GLITCH_CLKS`, 8: consecutive differing samples required before the filtered level changes.
- `MIN_VS_LINES`, 2: minimum acceptable VSYNC low width in lines.
- `MAX_VS_LINES`, 4: maximum acceptable VSYNC low width in lines.
- `clk`  input  1  system clock, same clock as the CSYNC generator.
- `rst_n`  input  1  asynchronous active-low reset.
- `vsync_raw`  input  1  raw VSYNC, active low, asynchronous to `clk`.
- `vsync`  output  1  clean VSYNC, active low, registered.
- `frame_lines`  output  10  lines between the last two `vsync` falling edges, saturating at 1023.
- `vs_lines`  output  3  width of the last `vsync` low period, rounded to whole lines, saturating at 7.
- `frame_strobe`  output  1  one-clock pulse when `frame_lines` updates.
- `locked`  output  1  frame structure stable.

## Operation
- **Synchronizer.** Two flops `s1` and `s2`, both reset to 1.
- **Filter.**
  - `gcnt` counts consecutive clocks where `s2 != vsync`. It clears whenever they are equal.
  - When `gcnt == GLITCH_CLKS-1` and `s2 != vsync`, `vsync` takes `s2` on that edge and `gcnt` clears.
- **Clock counter `ccnt`.** Runs 0..`LINE_CLKS`-1 and wraps.
- **Line counter `lcnt`.** 10 bits, incremented on `ccnt` wrap, saturating at 1023.
- **Falling edge of `vsync`.** Both `ccnt` and `lcnt` clear to 0 on the same edge as the fall.
- **FSM states:**
  - IDLE (reset state): waiting for the first `vsync` fall. Go to VS_LOW on fall; no strobe.
  - VS_LOW: on `vsync` rise, latch `vs_lines`, then go to ACTIVE.
    - `vs_lines` = `lcnt` + (`ccnt` ≥ `LINE_CLKS`/2 ? 1 : 0), saturated to 7.
  - ACTIVE: on `vsync` fall, `frame_lines` <= `lcnt` + (`ccnt` ≥ `LINE_CLKS`/2), saturated, then pulse `frame_strobe` and go to VS_LOW.
  - Any state except IDLE: if `lcnt` reaches 1023, this is a timeout. Go to IDLE, clear `locked`, leave `frame_lines` and `vs_lines` unchanged.
- **Frame validity.** A frame is valid when the `vs_lines` latched in that frame is within [`MIN_VS_LINES`, `MAX_VS_LINES`] and `frame_lines` is within ±1 of the previous `frame_lines`.
- **`good` counter.** 2 bits, saturating. Each strobe of a valid frame increments it; an invalid frame clears it.
- **`locked`.**
  - Set on the strobe that makes `good` = 2.
  - Cleared on the same edge as the strobe of an invalid frame, and on timeout.
- **Reset values.** Asserting `rst_n` mid-frame immediately returns everything to reset values.
  - `vsync`=1, `frame_lines`=0, `vs_lines`=0, `frame_strobe`=0, `locked`=0.
  - `ccnt`=0, `lcnt`=0, `gcnt`=0, `good`=0, state IDLE.

## Timing
- **Input to `vsync` latency.** A `vsync_raw` edge stable before clock edge k appears on `vsync` after edge k+1+`GLITCH_CLKS`. With defaults that is 10 clocks, equal for both polarities.
- **Pulses that never reach `vsync`.** A raw pulse of ≤ `GLITCH_CLKS`-1 clocks produces no change on `vsync`. A pulse of ≥ `GLITCH_CLKS` clocks is passed through with its width preserved.
- **Registered outputs.** `frame_lines`, `frame_strobe` and `locked` update on the same edge as the `vsync` fall. `vs_lines` updates on the same edge as the `vsync` rise.
- **Counter rounding.** `lcnt` counts whole elapsed lines. Rounding uses the value of `ccnt` at the edge.
- **Simultaneous events.**
  - If a `vsync` fall coincides with a `ccnt` wrap, the clear wins.
  - If a timeout coincides with an edge, the timeout wins.

## Test plan
- Reset, then raw high for 766×310 clocks, low for 766×3, high for 766×310, low for 766×3 -> first fall gives no strobe.
  - First rise -> `vs_lines`=3.
  - Second fall -> strobe, `frame_lines`=313, `locked`=0.
  - Third fall -> `locked`=1.
- Raw low pulse of 7 clocks -> `vsync` stays 1. Pulse of 8 clocks -> `vsync` low for exactly 8 clocks, starting 10 clocks after the raw edge.
- Locked stream, then one frame of 320 lines -> on that fall `locked`=0 and `frame_lines`=320. Lock returns two valid frames later.
- Locked stream with VSYNC held low for 6 lines -> `vs_lines`=6. At the next fall `locked`=0.
- Raw held high for 1100 lines after lock -> `locked` drops at `lcnt`=1023 and the FSM is in IDLE. The next fall produces no strobe.
- Assert `rst_n` during VS_LOW -> all outputs at reset values asynchronously. Release -> normal acquisition restarts.
